// File: rtl/pseudo_op_expander.sv
// pseudo_op_expander: expands pseudo-instructions (opcode 4'b1111) into one
// to three R-type XOR words ahead of the IR write path. Real instructions
// pass through unchanged with one cycle of latency.
// Optional feature: define PSEUDO_SWAP_EN to enable the 3-word swap sub-op;
// without it sub-op 2'b00 is reported as illegal like 2'b10/2'b11.
module pseudo_op_expander (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        illegal,
    output logic [7:0]  pseudo_cnt
);

    localparam logic [3:0] PSEUDO_OP = 4'b1111;
    localparam logic [3:0] XOR_FUNCT = 4'b0110;

    localparam logic [1:0] SUB_SWAP = 2'b00;
    localparam logic [1:0] SUB_CLR  = 2'b01;

`ifdef PSEUDO_SWAP_EN
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSwap2 = 2'd1,
        StSwap3 = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        StIdle = 1'b0
    } state_e;
`endif

    state_e      r_state, w_state_d;
    logic [15:0] r_out_instr, w_out_instr_d;
    logic        r_out_valid, w_out_valid_d;
    logic        r_illegal, w_illegal_d;
    logic [7:0]  r_cnt, w_cnt_d;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_hs;
    logic        w_is_pseudo;
    logic [2:0]  w_in_ra;
    logic [2:0]  w_in_rb;
    logic [1:0]  w_in_sub;
    logic [7:0]  w_cnt_inc;

`ifdef PSEUDO_SWAP_EN
    // Swap operands are kept so the later words can be rebuilt after accept.
    logic [2:0]  r_ra, w_ra_d;
    logic [2:0]  r_rb, w_rb_d;
`endif

    // R-type XOR word: {op=0, ra, rb, XOR_FUNCT, sub=0}.
    function automatic logic [15:0] xor_word(input logic [2:0] ra, input logic [2:0] rb);
        return {4'b0000, ra, rb, XOR_FUNCT, 2'b00};
    endfunction

    assign w_in_ra     = in_instr[11:9];
    assign w_in_rb     = in_instr[8:6];
    assign w_in_sub    = in_instr[1:0];
    assign w_is_pseudo = (in_instr[15:12] == PSEUDO_OP);

    assign w_in_ready = (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // Next-state: accept a new word, or advance the expansion on handshake.
    always_comb begin
        w_state_d     = r_state;
        w_out_instr_d = r_out_instr;
        w_out_valid_d = r_out_valid;
        w_illegal_d   = 1'b0;
        w_cnt_d       = r_cnt;
`ifdef PSEUDO_SWAP_EN
        w_ra_d        = r_ra;
        w_rb_d        = r_rb;
`endif

        if (w_accept) begin
            // Accept only happens in idle, so any current word is being consumed.
            if (!w_is_pseudo) begin
                w_out_instr_d = in_instr;
                w_out_valid_d = 1'b1;
            end else if (w_in_sub == SUB_CLR) begin
                w_out_instr_d = xor_word(w_in_ra, w_in_ra);
                w_out_valid_d = 1'b1;
                w_cnt_d       = w_cnt_inc;
`ifdef PSEUDO_SWAP_EN
            end else if (w_in_sub == SUB_SWAP) begin
                w_out_instr_d = xor_word(w_in_ra, w_in_rb);
                w_out_valid_d = 1'b1;
                w_cnt_d       = w_cnt_inc;
                w_ra_d        = w_in_ra;
                w_rb_d        = w_in_rb;
                w_state_d     = StSwap2;
`endif
            end else begin
                w_out_valid_d = 1'b0;
                w_illegal_d   = 1'b1;
            end
        end else if (w_out_hs) begin
            unique case (r_state)
`ifdef PSEUDO_SWAP_EN
                StSwap2: begin
                    w_out_instr_d = xor_word(r_rb, r_ra);
                    w_state_d     = StSwap3;
                end
                StSwap3: begin
                    w_out_instr_d = xor_word(r_ra, r_rb);
                    w_state_d     = StIdle;
                end
`endif
                default: begin
                    w_out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset discards any pending words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_out_instr <= 16'h0000;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= 8'h00;
        end else begin
            r_state     <= w_state_d;
            r_out_instr <= w_out_instr_d;
            r_out_valid <= w_out_valid_d;
            r_illegal   <= w_illegal_d;
            r_cnt       <= w_cnt_d;
        end
    end

`ifdef PSEUDO_SWAP_EN
    // Saved swap operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ra <= 3'd0;
            r_rb <= 3'd0;
        end else begin
            r_ra <= w_ra_d;
            r_rb <= w_rb_d;
        end
    end
`endif

    assign in_ready   = w_in_ready;
    assign out_instr  = r_out_instr;
    assign out_valid  = r_out_valid;
    assign busy       = r_out_valid || (r_state != StIdle);
    assign illegal    = r_illegal;
    assign pseudo_cnt = r_cnt;

endmodule

// File: doc/pseudo_op_expander.md
# pseudo_op_expander

Expands pseudo-instructions into real machine words ahead of the register-file/control unit. It sits between the instruction source (memory or test injector) and the IR write path. Real instructions pass through unchanged. Pseudo-ops (opcode PSEUDO_OP) become one to three R-type XOR instructions, issued one per accepted output handshake.

## Interface
- PSEUDO_OP, 4'b1111, opcode [15:12] that marks a pseudo-instruction
- XOR_FUNCT, 4'b0110, funct [5:2] placed in generated R-type words
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- in_instr  input  16  incoming instruction word
- in_valid  input  1  in_instr valid
- in_ready  output  1  expander accepts in_instr this cycle
- out_instr  output  16  real instruction to IR
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer (IR write) takes out_instr this cycle
- busy  output  1  out_valid or words pending
- illegal  output  1  one-cycle pulse: unsupported pseudo sub-op accepted
- pseudo_cnt  output  8  accepted legal pseudo-ops, saturating

## Operation
- Word fields: op [15:12], ra [11:9], rb [8:6], funct [5:2], sub [1:0]. R-type word = {4'b0000, ra, rb, XOR_FUNCT, 2'b00}.
- Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- in_ready = (remaining == 0) && (!out_valid || out_ready). This is combinational from registered state.
- States: IDLE (remaining 0), SWAP2 (2 words left after current), SWAP3 (1 left).
- On accept with op != PSEUDO_OP: out_instr <= in_instr, out_valid <= 1, remain IDLE.
- On accept with pseudo sub 2'b00 (swap ra,rb): emit xor(ra,rb), then xor(rb,ra), then xor(ra,rb). The first word loads on accept and the state goes to SWAP2. Each output handshake loads the next word: SWAP2->SWAP3->IDLE.
- On accept with pseudo sub 2'b01 (clr ra): emit the single word xor(ra,ra).
- On accept with pseudo sub 2'b10/2'b11: no word emitted. illegal pulses for one cycle, and pseudo_cnt is unchanged.
- pseudo_cnt increments on acceptance of each legal pseudo-op and saturates at 8'hFF.
- Output handshake with remaining 0 and no simultaneous accept: out_valid <= 0.
- busy = out_valid || (state != IDLE).

## Timing
- Reset values: out_instr 16'h0000, out_valid 0, illegal 0, pseudo_cnt 0, state IDLE. This gives in_ready 1 and busy 0.
- Latency: an output word is valid on the cycle after accept.
- Pass-through throughput: one word per cycle when out_ready is held high.
- Swap occupies 3 output handshakes. in_ready stays low until the handshake of the third word, and that same cycle may accept a new input.
- out_ready low: out_instr and out_valid are held stable and the state does not advance.
- Simultaneous final handshake and accept: the new word replaces the old one with no bubble.
- Reset mid-swap: the remaining words are discarded immediately, and outputs return to reset values asynchronously.
- illegal is registered and asserts the cycle after accept.

## Configuration
- PSEUDO_SWAP_EN defined: swap (sub 2'b00) expands as described above.
- PSEUDO_SWAP_EN undefined: states SWAP2/SWAP3 are omitted, and sub 2'b00 is treated as illegal (pulse, no output, no count).

## Test plan
- Reset, then in_instr 16'h1234 with out_ready 1 -> out_instr 16'h1234 with out_valid the next cycle. pseudo_cnt 0.
- Swap r3,r4: in 16'hF700 with out_ready 1 -> outputs 16'h0718, 16'h08D8, 16'h0718 on consecutive cycles. in_ready low for 2 cycles. pseudo_cnt 1.
- Clr r5: in 16'hFA01 -> single output 16'h0B58. pseudo_cnt increments by 1.
- Illegal: in 16'hF002 -> illegal pulses one cycle, out_valid stays 0, pseudo_cnt unchanged.
- Swap 16'hF700 with out_ready low for 4 cycles after the first word -> 16'h0718 held stable, no state advance. Release gives the sequence completing intact. Reset asserted before the third word -> out_valid 0 and in_ready 1.
- 256 clr ops -> pseudo_cnt saturates at 8'hFF. Rebuild without PSEUDO_SWAP_EN: 16'hF700 -> illegal pulse, no output.
